// File: rtl/gt_refclk_ctrl.sv
// gt_refclk_ctrl
//   Brings up one differential GT reference clock buffer and supervises it.
//   The buffer is held disabled (CEB=1) for a power-up interval and then
//   enabled. After a settle interval the divided buffer output (ODIV2) is
//   measured against CLK over a fixed window. An in-range count gives LOCKED.
//   Repeated failures give FAULT. While LOCKED, the clock is re-measured
//   continuously, and a bad window restarts bring-up.
//
// Ports
//   CLK         system clock, all logic on the rising edge
//   RST         synchronous reset, active-high
//   ENABLE      level request to bring up and hold the reference clock
//   REFCLK_DIV  buffer ODIV2 output, asynchronous to CLK
//   CEB         buffer clock-disable, 1 = disabled
//   READY       reference clock verified in range
//   FAULT       bring-up exhausted its retries
//   FREQ_CNT    rising-edge count of the last completed window
//   RETRY_CNT   failed attempts since the last LOCKED/IDLE
//   STATE       encoded FSM state (IDLE=0 .. FAULT=6)
module gt_refclk_ctrl #(
   parameter int unsigned PWRUP_CYC  = 16,
   parameter int unsigned SETTLE_CYC = 64,
   parameter int unsigned WIN_CYC    = 1024,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned CNT_MIN    = 200,
   parameter int unsigned CNT_MAX    = 312,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENABLE,
   input  logic             REFCLK_DIV,
   output logic             CEB,
   output logic             READY,
   output logic             FAULT,
   output logic [CNT_W-1:0] FREQ_CNT,
   output logic [1:0]       RETRY_CNT,
   output logic [2:0]       STATE
);

   localparam int unsigned SEQ_MAX = (PWRUP_CYC > SETTLE_CYC) ? PWRUP_CYC : SETTLE_CYC;
   localparam int unsigned SEQ_W   = $clog2(SEQ_MAX) + 1;
   localparam int unsigned WIN_W   = $clog2(WIN_CYC) + 1;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StPwrup   = 3'd1,
      StSettle  = 3'd2,
      StMeasure = 3'd3,
      StCheck   = 3'd4,
      StLocked  = 3'd5,
      StFault   = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]   freq_q, freq_d;
   logic [1:0]         retry_q, retry_d;
   logic               ceb_q, ready_q, fault_q;
   logic               sync1_q, sync2_q, sync3_q;
   logic               edge_pulse;
   logic [CNT_W-1:0]   edge_next;
   logic               win_last;
   logic               freq_ok;
   logic               next_ok;

   // ODIV2 synchronizer and rising-edge detect; runs in every state
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= REFCLK_DIV;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign edge_pulse = sync2_q & ~sync3_q;

   // Saturating count including a pulse on the current cycle
   assign edge_next = (edge_pulse && (edge_cnt_q != {CNT_W{1'b1}})) ?
                      edge_cnt_q + 1'b1 : edge_cnt_q;
   assign win_last  = (win_cnt_q == WIN_W'(WIN_CYC - 1));
   assign freq_ok   = (freq_q >= CNT_W'(CNT_MIN)) && (freq_q <= CNT_W'(CNT_MAX));
   assign next_ok   = (edge_next >= CNT_W'(CNT_MIN)) && (edge_next <= CNT_W'(CNT_MAX));

   always_comb begin
      state_d    = state_q;
      seq_cnt_d  = seq_cnt_q;
      win_cnt_d  = win_cnt_q;
      edge_cnt_d = edge_cnt_q;
      freq_d     = freq_q;
      retry_d    = retry_q;

      if (!ENABLE) begin
         // Dropping the request abandons any window; FREQ_CNT keeps its value
         state_d    = StIdle;
         retry_d    = 2'd0;
         seq_cnt_d  = '0;
         win_cnt_d  = '0;
         edge_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d   = StPwrup;
               seq_cnt_d = '0;
            end
            StPwrup: begin
               if (seq_cnt_q == SEQ_W'(PWRUP_CYC - 1)) begin
                  state_d   = StSettle;
                  seq_cnt_d = '0;
               end else begin
                  seq_cnt_d = seq_cnt_q + 1'b1;
               end
            end
            StSettle: begin
               if (seq_cnt_q == SEQ_W'(SETTLE_CYC - 1)) begin
                  state_d    = StMeasure;
                  seq_cnt_d  = '0;
                  win_cnt_d  = '0;
                  edge_cnt_d = '0;
               end else begin
                  seq_cnt_d = seq_cnt_q + 1'b1;
               end
            end
            StMeasure: begin
               if (win_last) begin
                  freq_d  = edge_next;
                  state_d = StCheck;
               end else begin
                  win_cnt_d  = win_cnt_q + 1'b1;
                  edge_cnt_d = edge_next;
               end
            end
            StCheck: begin
               if (freq_ok) begin
                  state_d    = StLocked;
                  retry_d    = 2'd0;
                  win_cnt_d  = '0;
                  edge_cnt_d = '0;
               end else if ((32'(retry_q) + 32'd1) < MAX_RETRY) begin
                  state_d   = StPwrup;
                  retry_d   = retry_q + 2'd1;
                  seq_cnt_d = '0;
               end else begin
                  state_d = StFault;
                  retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
               end
            end
            StLocked: begin
               if (win_last) begin
                  freq_d     = edge_next;
                  win_cnt_d  = '0;
                  edge_cnt_d = '0;
                  if (!next_ok) begin
                     // Lost lock: first failed attempt of a fresh bring-up
                     state_d   = StPwrup;
                     retry_d   = 2'd1;
                     seq_cnt_d = '0;
                  end
               end else begin
                  win_cnt_d  = win_cnt_q + 1'b1;
                  edge_cnt_d = edge_next;
               end
            end
            StFault: begin
               state_d = StFault;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StIdle;
         seq_cnt_q  <= '0;
         win_cnt_q  <= '0;
         edge_cnt_q <= '0;
         freq_q     <= '0;
         retry_q    <= 2'd0;
         ceb_q      <= 1'b1;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_cnt_q  <= seq_cnt_d;
         win_cnt_q  <= win_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         freq_q     <= freq_d;
         retry_q    <= retry_d;
         // Outputs registered from the next state so they align with STATE
         ceb_q      <= (state_d == StIdle) || (state_d == StPwrup) || (state_d == StFault);
         ready_q    <= (state_d == StLocked);
         fault_q    <= (state_d == StFault);
      end
   end

   assign CEB       = ceb_q;
   assign READY     = ready_q;
   assign FAULT     = fault_q;
   assign FREQ_CNT  = freq_q;
   assign RETRY_CNT = retry_q;
   assign STATE     = state_q;

endmodule

// File: tb/tb_gt_refclk_ctrl.sv
// Testbench for gt_refclk_ctrl. Stimulus pushes the expected sequence of
// state records into a queue. A monitor pops one record on every STATE
// change and compares outputs plus the cycles spent in the previous state.
module tb_gt_refclk_ctrl;

   localparam int PW  = 16;
   localparam int SET = 64;
   localparam int WIN = 1024;

   localparam logic [2:0] S_IDLE = 3'd0, S_PWRUP = 3'd1, S_SETTLE = 3'd2, S_MEAS = 3'd3,
                          S_CHECK = 3'd4, S_LOCKED = 3'd5, S_FAULT = 3'd6;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        refclk_div;
   logic        ceb;
   logic        ready;
   logic        fault;
   logic [15:0] freq_cnt;
   logic [1:0]  retry_cnt;
   logic [2:0]  state;

   gt_refclk_ctrl dut (
      .CLK        (clk),
      .RST        (rst),
      .ENABLE     (enable),
      .REFCLK_DIV (refclk_div),
      .CEB        (ceb),
      .READY      (ready),
      .FAULT      (fault),
      .FREQ_CNT   (freq_cnt),
      .RETRY_CNT  (retry_cnt),
      .STATE      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic       ceb;
      logic       rdy;
      logic       flt;
      logic [1:0] rty;
      int         freq;  // -1: not checked
      int         dt;    // cycles in previous state, 0: not checked
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   mon_en  = 1'b0;

   // ODIV2 generator: 0 = stuck low, 1 = period 4 CLK, 2 = burst of N edges
   int   gen_mode = 0;
   int   burst_n  = 0;
   int   burst_id = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void push(input logic [2:0] st, input logic c, input logic r,
                                input logic f, input logic [1:0] rt, input int fr,
                                input int dt);
      exp_t e;
      e.st = st; e.ceb = c; e.rdy = r; e.flt = f; e.rty = rt; e.freq = fr; e.dt = dt;
      q.push_back(e);
   endfunction

   // One bring-up attempt; LOCKED appended only when the count is in range
   function automatic void push_bringup(input logic [1:0] rt, input int fexp, input bit ok,
                                        input int pw_dt);
      push(S_PWRUP, 1'b1, 1'b0, 1'b0, rt, -1, pw_dt);
      push(S_SETTLE, 1'b0, 1'b0, 1'b0, rt, -1, PW);
      push(S_MEAS, 1'b0, 1'b0, 1'b0, rt, -1, SET);
      push(S_CHECK, 1'b0, 1'b0, 1'b0, rt, fexp, WIN);
      if (ok) push(S_LOCKED, 1'b0, 1'b1, 1'b0, 2'd0, fexp, 1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int limit);
      int n;
      n = 0;
      while (state != s && n < limit) begin
         step();
         n++;
      end
      if (state != s) begin
         n_total++;
         $display("FAIL wait_state: got state %0d expected %0d within %0d cycles",
                  state, s, limit);
      end
   endtask

   // Generator
   initial begin
      logic [1:0] ph;
      int         seen;
      int         left;
      ph = 2'd0; seen = 0; left = 0;
      refclk_div = 1'b0;
      forever begin
         @(negedge clk);
         case (gen_mode)
            1: begin
               ph = ph + 2'd1;
               refclk_div = ph[1];
            end
            2: begin
               if (burst_id != seen) begin
                  seen = burst_id;
                  left = burst_n;
               end
               if (left > 0) begin
                  if (!refclk_div) begin
                     refclk_div = 1'b1;
                     left--;
                  end else begin
                     refclk_div = 1'b0;
                  end
               end else begin
                  refclk_div = 1'b0;
               end
            end
            default: refclk_div = 1'b0;
         endcase
      end
   end

   // Monitor
   initial begin
      logic [2:0] prev;
      int         cyc;
      int         last;
      exp_t       e;
      prev = 3'd7; cyc = 0; last = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en && state != prev) begin
            int dt;
            dt   = cyc - last;
            last = cyc;
            prev = state;
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL sb_unexpected: state changed to %0d with no expectation", state);
            end else begin
               e = q.pop_front();
               chk("state", int'(state), int'(e.st));
               chk("ceb", int'(ceb), int'(e.ceb));
               chk("ready", int'(ready), int'(e.rdy));
               chk("fault", int'(fault), int'(e.flt));
               chk("retry_cnt", int'(retry_cnt), int'(e.rty));
               if (e.freq >= 0) chk("freq_cnt", int'(freq_cnt), e.freq);
               if (e.dt > 0) chk("state_cycles", dt, e.dt);
            end
         end
      end
   end

   // Stimulus
   initial begin
      int  nvec[4];
      bit  ok;
      rst = 1'b1;
      enable = 1'b0;
      repeat (3) step();
      push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0);
      mon_en = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Nominal bring-up: 256 edges per window
      gen_mode = 1;
      push_bringup(2'd0, 256, 1'b1, 0);
      enable = 1'b1;
      wait_state(S_LOCKED, 2000);

      // Clock stops 500 cycles into the second LOCKED window, then resumes
      push_bringup(2'd1, 256, 1'b1, 2 * WIN);
      repeat (WIN + 500) step();
      gen_mode = 0;
      wait_state(S_PWRUP, 3000);
      gen_mode = 1;
      wait_state(S_LOCKED, 2000);

      push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, 256, 0);
      enable = 1'b0;
      repeat (3) step();

      // Stuck low: three attempts then FAULT
      gen_mode = 0;
      push_bringup(2'd0, 0, 1'b0, 0);
      push_bringup(2'd1, 0, 1'b0, 1);
      push_bringup(2'd2, 0, 1'b0, 1);
      push(S_FAULT, 1'b1, 1'b0, 1'b1, 2'd3, 0, 1);
      enable = 1'b1;
      wait_state(S_FAULT, 4000);
      repeat (5) step();
      push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0);
      enable = 1'b0;
      repeat (3) step();

      // Boundary counts
      nvec[0] = 200; nvec[1] = 312; nvec[2] = 199; nvec[3] = 313;
      gen_mode = 2;
      for (int i = 0; i < 4; i++) begin
         ok = (nvec[i] >= 200) && (nvec[i] <= 312);
         push_bringup(2'd0, nvec[i], ok, 0);
         if (!ok) push(S_PWRUP, 1'b1, 1'b0, 1'b0, 2'd1, nvec[i], 1);
         push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, nvec[i], 0);
         enable = 1'b1;
         wait_state(S_MEAS, 200);
         repeat (20) step();
         burst_n = nvec[i];
         burst_id++;
         wait_state(ok ? S_LOCKED : S_PWRUP, 1500);
         enable = 1'b0;
         repeat (3) step();
      end

      // ENABLE dropped mid-MEASURE: FREQ_CNT keeps 313
      gen_mode = 1;
      push(S_PWRUP, 1'b1, 1'b0, 1'b0, 2'd0, 313, 0);
      push(S_SETTLE, 1'b0, 1'b0, 1'b0, 2'd0, 313, PW);
      push(S_MEAS, 1'b0, 1'b0, 1'b0, 2'd0, 313, SET);
      push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, 313, 301);
      enable = 1'b1;
      wait_state(S_MEAS, 200);
      repeat (300) step();
      enable = 1'b0;
      repeat (3) step();

      // Re-enable gives the full sequence
      push_bringup(2'd0, 256, 1'b1, 0);
      enable = 1'b1;
      wait_state(S_LOCKED, 2000);
      repeat (100) step();

      // RST during LOCKED with ENABLE held
      push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0);
      push_bringup(2'd0, 256, 1'b1, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_state(S_LOCKED, 2000);

      push(S_IDLE, 1'b1, 1'b0, 1'b0, 2'd0, 256, 0);
      enable = 1'b0;
      repeat (5) step();
      chk("sb_drain", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
